turf_command_processor: RTL and testbench
=========================================

# turf_command_processor

Sysclk-domain consumer of the 32-bit TURF command words produced by the TURF control interface. It accepts words only while the command path is locked and decodes them into three actions: trigger pulses, register writes and register reads. Register accesses are buffered in a 4-entry FIFO and issued over a req/ack register port. Each completed access is reflected back as a 32-bit response word for the COUTTIO response path.

## Interface
- `FIFO_DEPTH`, 4: register-command FIFO depth; power of two, minimum 2.
- `sysclk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `command_i`  in  32  command word from the CIN parallel sync.
- `command_valid_i`  in  1  `command_i` is valid this cycle.
- `command_locked_i`  in  1  CIN sync is locked onto the command stream.
- `trig_o`  out  1  single-cycle trigger strobe.
- `trig_payload_o`  out  16  trigger payload; held until the next trigger.
- `reg_req_o`  out  1  register access request.
- `reg_we_o`  out  1  1 = write, 0 = read; valid while `reg_req_o` is high.
- `reg_addr_o`  out  14  register address.
- `reg_dat_o`  out  16  write data.
- `reg_dat_i`  in  16  read data; sampled when `reg_ack_i` is high.
- `reg_ack_i`  in  1  access complete.
- `response_o`  out  32  last response word; feeds the interface `response_i`.
- `illegal_count_o`  out  16  count of illegal commands.
- `overflow_count_o`  out  16  count of commands dropped because the FIFO was full.

## Operation
- Accept a word when `command_valid_i && command_locked_i`. Ignore words while unlocked.
- Decode on `command_i[31:30]`:
  - 00 IDLE: the word must be 0x00000000. Any nonzero payload is illegal and is discarded.
  - 01 TRIGGER: `trig_payload_o <= command_i[15:0]`, and `trig_o` pulses.
  - 10 WRITE: push {we=1, addr=`[29:16]`, data=`[15:0]`} into the FIFO.
  - 11 READ: push {we=0, addr=`[29:16]`, data=don't care} into the FIFO.
- FIFO entries are 31 bits. A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and the overflow counter increments.
- Issue FSM:
  - IDLE → REQ when the FIFO is not empty. The head entry drives `reg_we_o`, `reg_addr_o` and `reg_dat_o`; `reg_req_o` = 1.
  - REQ holds all outputs stable until `reg_ack_i`. On ack: pop the FIFO, go to IDLE, and drop `reg_req_o` the next cycle.
  - `reg_ack_i` outside REQ is ignored.
- Response on ack:
  - Write: `response_o <= {2'b10, addr, data}`.
  - Read: `response_o <= {2'b11, addr, reg_dat_i}`.
- Falling edge of `command_locked_i`: flush all FIFO entries not yet issued. An access already in REQ runs to ack and still updates `response_o`.
- Counters are 16-bit and saturate at 0xFFFF.

## Timing
- Reset values:
  - `trig_o`, `reg_req_o`, `reg_we_o` = 0.
  - `trig_payload_o`, `reg_addr_o`, `reg_dat_o`, `response_o` = 0.
  - Both counters = 0; FIFO empty; FSM in IDLE.
- Trigger: valid word at cycle N → `trig_o` high at N+1 only. Back-to-back triggers give back-to-back pulses.
- Register command at cycle N → FIFO push at N+1 → `reg_req_o` high at N+2 at the earliest (FIFO empty and FSM idle).
- Ack at cycle M → `reg_req_o` low at M+1 → next request no earlier than M+2. A one-cycle gap between requests is guaranteed.
- `response_o` updates at M+1.
- Flush and push in the same cycle: the flush wins, and the pushed word is lost without being counted.
- Reset mid-access drops the request immediately and empties the FIFO.

## Configuration
- `TURF_CMD_STATS_EN` defined: both saturating counters are built and behave as described above.
- Not defined: `illegal_count_o` and `overflow_count_o` are tied to 0 and no counter logic is built. Decode and drop behaviour is unchanged.

## Test plan
- Locked, valid 0x4000ABCD → `trig_o` high exactly one cycle, two cycles after reset release plus input; `trig_payload_o` = 0xABCD.
- WRITE 0x80051234 with `reg_ack_i` returned 3 cycles after req → `reg_addr_o` = 0x0005, `reg_dat_o` = 0x1234, `reg_we_o` = 1; `response_o` = 0x80051234 after ack.
- READ 0xC0070000 acked with `reg_dat_i` = 0xBEEF → `response_o` = 0xC007BEEF.
- Six WRITEs on consecutive cycles, ack withheld → 4 entries queued, `overflow_count_o` = 2. Release acks → exactly 4 accesses issued, in order, each separated by at least one idle cycle.
- Word 0x00000001 locked, then 0x40000001 with `command_locked_i` = 0 → `illegal_count_o` = 1, no `trig_o`.
- Three WRITEs queued, drop lock while the first is in REQ → the first completes, the remaining two are never requested. Then assert `rst_i` during a new REQ → `reg_req_o` low asynchronously.

Source files
------------

// File: rtl/turf_command_processor.sv
// TURF command word decoder: trigger strobes plus FIFO-buffered register accesses over req/ack.
// Define TURF_CMD_STATS_EN to build the saturating illegal/overflow counters.
module turf_command_processor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic [31:0] command_i,
    input  logic        command_valid_i,
    input  logic        command_locked_i,
    output logic        trig_o,
    output logic [15:0] trig_payload_o,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [13:0] reg_addr_o,
    output logic [15:0] reg_dat_o,
    input  logic [15:0] reg_dat_i,
    input  logic        reg_ack_i,
    output logic [31:0] response_o,
    output logic [15:0] illegal_count_o,
    output logic [15:0] overflow_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t        state_q, state_d;
    logic [30:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          locked_q;
    logic          trig_q, trig_d;
    logic [15:0]   trig_payload_q, trig_payload_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [13:0]   addr_q, addr_d;
    logic [15:0]   dat_q, dat_d;
    logic [31:0]   response_q, response_d;

    logic        accept, is_trig, is_reg, flush, fifo_full, fifo_empty, pop, push;
    logic [30:0] head;

    assign accept     = command_valid_i && command_locked_i;
    assign is_trig    = accept && (command_i[31:30] == 2'b01);
    assign is_reg     = accept && command_i[31];
    assign flush      = locked_q && !command_locked_i;
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == ST_REQ) && reg_ack_i && !fifo_empty;
    assign push       = is_reg && (!fifo_full || pop) && !flush;
    assign head       = fifo_mem_q[rd_ptr_q];

    // Entry layout {we, addr[13:0], data[15:0]}; we is the inverse of opcode bit 30.
    always_ff @(posedge sysclk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {~command_i[30], command_i[29:0]};
        end
    end

    always_comb begin
        trig_d         = is_trig;
        trig_payload_d = is_trig ? command_i[15:0] : trig_payload_q;
        rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d        = count_q + CW'(push) - CW'(pop);
        // The head stays in the FIFO while in flight, so a flush keeps exactly that one entry.
        if (flush) begin
            if (state_q == ST_REQ && !pop) begin
                wr_ptr_d = rd_ptr_q + AW'(1);
                count_d  = CW'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
        end

        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        response_d = response_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = head[30];
                    addr_d  = head[29:16];
                    dat_d   = head[15:0];
                end
            end
            ST_REQ: begin
                if (reg_ack_i) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    response_d = {1'b1, ~we_q, addr_q, we_q ? dat_q : reg_dat_i};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            locked_q       <= 1'b0;
            trig_q         <= 1'b0;
            trig_payload_q <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            dat_q          <= '0;
            response_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            locked_q       <= command_locked_i;
            trig_q         <= trig_d;
            trig_payload_q <= trig_payload_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            dat_q          <= dat_d;
            response_q     <= response_d;
        end
    end

    assign trig_o         = trig_q;
    assign trig_payload_o = trig_payload_q;
    assign reg_req_o      = req_q;
    assign reg_we_o       = we_q;
    assign reg_addr_o     = addr_q;
    assign reg_dat_o      = dat_q;
    assign response_o     = response_q;

`ifdef TURF_CMD_STATS_EN
    logic        is_illegal, overflow;
    logic [15:0] illegal_count_q, illegal_count_d;
    logic [15:0] overflow_count_q, overflow_count_d;

    assign is_illegal = accept && (command_i[31:30] == 2'b00) && (command_i[29:0] != '0);
    // A word lost to a flush is not an overflow.
    assign overflow   = is_reg && fifo_full && !pop && !flush;

    always_comb begin
        illegal_count_d  = illegal_count_q;
        overflow_count_d = overflow_count_q;
        if (is_illegal && illegal_count_q != 16'hFFFF) begin
            illegal_count_d = illegal_count_q + 16'd1;
        end
        if (overflow && overflow_count_q != 16'hFFFF) begin
            overflow_count_d = overflow_count_q + 16'd1;
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_count_q  <= '0;
            overflow_count_q <= '0;
        end else begin
            illegal_count_q  <= illegal_count_d;
            overflow_count_q <= overflow_count_d;
        end
    end

    assign illegal_count_o  = illegal_count_q;
    assign overflow_count_o = overflow_count_q;
`else
    assign illegal_count_o  = '0;
    assign overflow_count_o = '0;
`endif

endmodule

// File: tb/tb_turf_command_processor.sv
// Directed bench for turf_command_processor: decode vector table plus register-access sequences.
module tb_turf_command_processor;
`ifdef TURF_CMD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] command = '0;
    logic        command_valid = 1'b0;
    logic        command_locked = 1'b0;
    logic        trig;
    logic [15:0] trig_payload;
    logic        reg_req, reg_we;
    logic [13:0] reg_addr;
    logic [15:0] reg_dat_o_w;
    logic [15:0] reg_dat_i_r = '0;
    logic        reg_ack = 1'b0;
    logic [31:0] response;
    logic [15:0] illegal_count, overflow_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turf_command_processor #(.FIFO_DEPTH(4)) dut (
        .sysclk_i(clk),
        .rst_i(rst),
        .command_i(command),
        .command_valid_i(command_valid),
        .command_locked_i(command_locked),
        .trig_o(trig),
        .trig_payload_o(trig_payload),
        .reg_req_o(reg_req),
        .reg_we_o(reg_we),
        .reg_addr_o(reg_addr),
        .reg_dat_o(reg_dat_o_w),
        .reg_dat_i(reg_dat_i_r),
        .reg_ack_i(reg_ack),
        .response_o(response),
        .illegal_count_o(illegal_count),
        .overflow_count_o(overflow_count)
    );

    typedef struct {
        logic [31:0] cmd;
        logic        valid;
        logic        locked;
        logic        exp_trig;
        logic [15:0] exp_payload;
        logic [15:0] exp_ill;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] cmd);
        command       = cmd;
        command_valid = 1'b1;
        tick();
        command_valid = 1'b0;
        command       = '0;
    endtask

    task automatic do_access(input string nm, input logic exp_we, input logic [13:0] exp_addr,
                             input logic [15:0] exp_dat, input bit chk_dat, input logic [15:0] rdata,
                             input int delay, input logic [31:0] exp_resp);
        int waited = 0;
        while (!reg_req && waited < 20) begin
            tick();
            waited++;
        end
        chk({nm, "_req_seen"}, 32'(reg_req), 32'd1);
        chk({nm, "_we"}, 32'(reg_we), 32'(exp_we));
        chk({nm, "_addr"}, 32'(reg_addr), 32'(exp_addr));
        if (chk_dat) chk({nm, "_dat"}, 32'(reg_dat_o_w), 32'(exp_dat));
        for (int i = 0; i < delay; i++) tick();
        chk({nm, "_held"}, {15'd0, reg_req, reg_addr, 2'b00}, {15'd1, exp_addr, 2'b00});
        reg_dat_i_r = rdata;
        reg_ack     = 1'b1;
        tick();
        reg_ack     = 1'b0;
        chk({nm, "_req_drop"}, 32'(reg_req), 32'd0);
        chk({nm, "_resp"}, response, exp_resp);
        $display("access %s we=%0d addr=%h resp=%h", nm, exp_we, exp_addr, response);
    endtask

    initial begin
        int req_cycles;

        vecs[0] = '{32'h4000ABCD, 1'b1, 1'b1, 1'b1, 16'hABCD, 16'd0};
        vecs[1] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'd0};
        vecs[2] = '{32'h00000001, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'd1};
        vecs[3] = '{32'h40000001, 1'b1, 1'b0, 1'b0, 16'hABCD, 16'd1};
        vecs[4] = '{32'h40001111, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'd1};
        vecs[5] = '{32'h40002222, 1'b1, 1'b1, 1'b1, 16'h2222, 16'd1};
        vecs[6] = '{32'h40003333, 1'b1, 1'b1, 1'b1, 16'h3333, 16'd1};
        vecs[7] = '{32'h00010000, 1'b1, 1'b1, 1'b0, 16'h3333, 16'd2};
        vecs[8] = '{32'h7FFF5555, 1'b1, 1'b1, 1'b1, 16'h5555, 16'd2};

        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(reg_req), 32'd0);
        chk("rst_outs", {trig, reg_we, trig_payload, reg_addr}, 32'd0);
        chk("rst_dat", 32'(reg_dat_o_w), 32'd0);
        chk("rst_resp", response, 32'd0);
        chk("rst_counts", {illegal_count, overflow_count}, 32'd0);
        rst = 1'b0;
        command_locked = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            command        = vecs[i].cmd;
            command_valid  = vecs[i].valid;
            command_locked = vecs[i].locked;
            tick();
            chk($sformatf("vec%0d_trig", i), 32'(trig), 32'(vecs[i].exp_trig));
            chk($sformatf("vec%0d_payload", i), 32'(trig_payload), 32'(vecs[i].exp_payload));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal_count), STATS ? 32'(vecs[i].exp_ill) : 32'd0);
            $display("vec %0d cmd=%h trig=%0d payload=%h ill=%0d", i, vecs[i].cmd, trig, trig_payload, illegal_count);
        end
        command_valid  = 1'b0;
        command_locked = 1'b1;
        tick();
        chk("trig_single", 32'(trig), 32'd0);

        // Write, ack three cycles after request; earliest request is two cycles after the word
        send(32'h80051234);
        chk("wr_req_not_yet", 32'(reg_req), 32'd0);
        tick();
        chk("wr_req_latency", 32'(reg_req), 32'd1);
        do_access("wr", 1'b1, 14'h0005, 16'h1234, 1'b1, 16'h0000, 3, 32'h80051234);

        // Read
        send(32'hC0070000);
        do_access("rd", 1'b0, 14'h0007, 16'h0000, 1'b0, 16'hBEEF, 1, 32'hC007BEEF);

        // Six back-to-back writes with ack withheld
        for (int i = 1; i <= 6; i++) begin
            command       = {2'b10, 14'(i), 16'(i)};
            command_valid = 1'b1;
            tick();
        end
        command_valid = 1'b0;
        tick();
        chk("ovf_count", 32'(overflow_count), STATS ? 32'd2 : 32'd0);
        for (int i = 1; i <= 4; i++) begin
            do_access($sformatf("q%0d", i), 1'b1, 14'(i), 16'(i), 1'b1, 16'h0000, 0,
                      {2'b10, 14'(i), 16'(i)});
        end
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (reg_req) req_cycles++;
        end
        chk("ovf_only_four", 32'(req_cycles), 32'd0);

        // Lock drop while the first of three writes is in flight
        send(32'h8010AAAA);
        send(32'h8011BBBB);
        send(32'h8012CCCC);
        chk("flush_first_req", {reg_req, 17'd0, reg_addr}, {1'b1, 17'd0, 14'h0010});
        command_locked = 1'b0;
        tick();
        do_access("flush_first", 1'b1, 14'h0010, 16'hAAAA, 1'b1, 16'h0000, 2, 32'h8010AAAA);
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (reg_req) req_cycles++;
        end
        chk("flush_rest_dropped", 32'(req_cycles), 32'd0);
        command_locked = 1'b1;
        tick();

        // Asynchronous reset during a request
        send(32'h80200042);
        tick();
        chk("rst_mid_req_up", 32'(reg_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(reg_req), 32'd0);
        chk("rst_async_resp", response, 32'd0);
        #1 rst = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (reg_req) req_cycles++;
        end
        chk("rst_fifo_empty", 32'(req_cycles), 32'd0);
        chk("rst_counts_clear", {illegal_count, overflow_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
